// File: rtl/aer_pkg.sv
// Shared types and symbol encodings for the AER word assembler.
// Symbol order in every 6-bit vector: bit 0 Fs, 1 Fd, 2 Fe, 3 X0, 4 ZERO, 5 ONE.
package aer_pkg;

  typedef enum logic [2:0] {SYM_NONE, SYM_FS, SYM_FD, SYM_FE, SYM_X0, SYM_ZERO, SYM_ONE} sym_t;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ACK} state_t;

  localparam int AER_ADDR_W = 8;
  localparam int NUM_SYM    = 6;

  localparam int IDX_FS   = 0;
  localparam int IDX_FD   = 1;
  localparam int IDX_FE   = 2;
  localparam int IDX_X0   = 3;
  localparam int IDX_ZERO = 4;
  localparam int IDX_ONE  = 5;

  // Anything other than exactly one high line decodes to SYM_NONE.
  function automatic sym_t decode_sym(input logic [NUM_SYM-1:0] v);
    case (v)
      6'b000001: return SYM_FS;
      6'b000010: return SYM_FD;
      6'b000100: return SYM_FE;
      6'b001000: return SYM_X0;
      6'b010000: return SYM_ZERO;
      6'b100000: return SYM_ONE;
      default:   return SYM_NONE;
    endcase
  endfunction

  function automatic logic [NUM_SYM-1:0] sym_onehot(input sym_t s);
    logic [NUM_SYM-1:0] v;
    v = '0;
    case (s)
      SYM_FS:   v[IDX_FS]   = 1'b1;
      SYM_FD:   v[IDX_FD]   = 1'b1;
      SYM_FE:   v[IDX_FE]   = 1'b1;
      SYM_X0:   v[IDX_X0]   = 1'b1;
      SYM_ZERO: v[IDX_ZERO] = 1'b1;
      SYM_ONE:  v[IDX_ONE]  = 1'b1;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aer_sync.sv
// Single-bit multi-flop synchroniser with asynchronous clear.
module aer_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/aer_word_assembler.sv
// Synchronises AER receiver symbols, completes their four-phase handshakes
// and assembles delimited bit runs into words on a valid/ready stream.
module aer_word_assembler
  import aer_pkg::*;
#(
  parameter int ADDR_W      = AER_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Fs,
  input  logic              Fd,
  input  logic              Fe,
  input  logic              X0,
  input  logic              ZERO_OUT,
  input  logic              ONE_OUT,
  output logic              FS_ACK,
  output logic              FD_ACK,
  output logic              FE_ACK,
  output logic              X0_ACK,
  output logic              ZERO_ACK,
  output logic              ONE_ACK,
  output logic [ADDR_W-1:0] word_data,
  output logic              word_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              err_len,
  output logic              err_proto,
  output logic              busy
);

  localparam int              CNT_W = $clog2(ADDR_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ADDR_W);

  logic [NUM_SYM-1:0] sym_raw, sym_s, sym_s_p0;
  sym_t               sym;
  logic               is_fe, slot_free;

  state_t             state, state_d;
  logic [NUM_SYM-1:0] ack, ack_d;
  logic               hold_fe, hold_fe_d;
  logic [ADDR_W-1:0]  shreg, shreg_d, word_data_d;
  logic [CNT_W-1:0]   count, count_d;
  logic               ovf, ovf_d, in_frame, in_frame_d;
  logic               word_last_d, word_valid_d, err_len_d, err_proto_d;

  assign sym_raw = {ONE_OUT, ZERO_OUT, X0, Fe, Fd, Fs};

  for (genvar i = 0; i < NUM_SYM; i++) begin : g_sync
    aer_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (reset),
      .d   (sym_raw[i]),
      .q   (sym_s[i])
    );
  end

  // Stage p0: a symbol qualifies after two consecutive high samples with all others low.
  assign sym       = ((sym_s & ~sym_s_p0) == '0) ? decode_sym(sym_s) : SYM_NONE;
  assign is_fe     = (sym == SYM_FE);
  assign slot_free = !word_valid || word_ready;

  always_comb begin
    state_d      = state;
    ack_d        = ack;
    hold_fe_d    = hold_fe;
    shreg_d      = shreg;
    count_d      = count;
    ovf_d        = ovf;
    in_frame_d   = in_frame;
    word_data_d  = word_data;
    word_last_d  = word_last;
    word_valid_d = word_valid && !word_ready;
    err_len_d    = 1'b0;
    err_proto_d  = 1'b0;

    case (state)
      S_IDLE: begin
        case (sym)
          SYM_FS: begin
            err_proto_d = in_frame;
            shreg_d     = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            in_frame_d  = 1'b1;
            ack_d       = sym_onehot(sym);
            state_d     = S_ACK;
          end
          SYM_ZERO, SYM_ONE: begin
            ack_d   = sym_onehot(sym);
            state_d = S_ACK;
            if (!in_frame) begin
              err_proto_d = 1'b1;
            end else if (count != FULL) begin
              shreg_d = {shreg[ADDR_W-2:0], sym == SYM_ONE};
              count_d = count + CNT_W'(1);
            end else begin
              // Only the first surplus bit of a word is reported.
              err_len_d = !ovf;
              ovf_d     = 1'b1;
            end
          end
          SYM_FD, SYM_FE: begin
            if (in_frame && count == FULL && !ovf && !slot_free) begin
              hold_fe_d = is_fe;
              state_d   = S_HOLD;
            end else begin
              if (in_frame && count == FULL && !ovf) begin
                word_data_d  = shreg;
                word_last_d  = is_fe;
                word_valid_d = 1'b1;
              end else if (!in_frame) begin
                err_proto_d = 1'b1;
              end else begin
                err_len_d = !ovf;
              end
              count_d = '0;
              ovf_d   = 1'b0;
              if (is_fe) in_frame_d = 1'b0;
              ack_d   = sym_onehot(sym);
              state_d = S_ACK;
            end
          end
          SYM_X0: begin
            ack_d   = sym_onehot(sym);
            state_d = S_ACK;
          end
          default: ;
        endcase
      end
      S_HOLD: begin
        if (slot_free) begin
          word_data_d  = shreg;
          word_last_d  = hold_fe;
          word_valid_d = 1'b1;
          count_d      = '0;
          ovf_d        = 1'b0;
          if (hold_fe) in_frame_d = 1'b0;
          ack_d        = sym_onehot(hold_fe ? SYM_FE : SYM_FD);
          state_d      = S_ACK;
        end
      end
      S_ACK: begin
        if ((sym_s & ack) == '0) begin
          ack_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p1: registered handshake, frame state and output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_s_p0   <= '0;
      state      <= S_IDLE;
      ack        <= '0;
      hold_fe    <= 1'b0;
      shreg      <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      in_frame   <= 1'b0;
      word_data  <= '0;
      word_last  <= 1'b0;
      word_valid <= 1'b0;
      err_len    <= 1'b0;
      err_proto  <= 1'b0;
    end else begin
      sym_s_p0   <= sym_s;
      state      <= state_d;
      ack        <= ack_d;
      hold_fe    <= hold_fe_d;
      shreg      <= shreg_d;
      count      <= count_d;
      ovf        <= ovf_d;
      in_frame   <= in_frame_d;
      word_data  <= word_data_d;
      word_last  <= word_last_d;
      word_valid <= word_valid_d;
      err_len    <= err_len_d;
      err_proto  <= err_proto_d;
    end
  end

  assign {ONE_ACK, ZERO_ACK, X0_ACK, FE_ACK, FD_ACK, FS_ACK} = ack;
  assign busy = in_frame || (ack != '0);

endmodule

// File: tb/tb_aer_word_assembler.sv
// Self-checking bench for aer_word_assembler: directed framing/backpressure/error/reset
// scenarios plus randomized frames against a transaction-level frame model.
module tb_aer_word_assembler;
  import aer_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int T_FS = 0, T_FD = 1, T_FE = 2, T_X0 = 3, T_ZERO = 4, T_ONE = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [5:0]        sym_in = '0;
  logic [5:0]        ack;
  logic [ADDR_W-1:0] word_data;
  logic              word_last, word_valid, err_len, err_proto, busy;
  logic              word_ready = 1'b0;

  int n_checks = 0, n_pass = 0;
  int n_len_seen = 0, n_proto_seen = 0, acc_count = 0;
  logic [ADDR_W-1:0] last_acc_data = '0;
  logic              last_acc_last = 1'b0;

  // transaction-level frame model
  bit                m_in = 0, m_ovf = 0;
  int                m_cnt = 0;
  logic [ADDR_W-1:0] m_bits = '0;
  int                exp_len = 0, exp_proto = 0;
  logic [ADDR_W:0]   exp_q[$];

  bit ready_rand = 0, ready_force = 1;

  always #5 clk = ~clk;

  aer_word_assembler #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk        (clk),
    .reset      (reset),
    .Fs         (sym_in[T_FS]),
    .Fd         (sym_in[T_FD]),
    .Fe         (sym_in[T_FE]),
    .X0         (sym_in[T_X0]),
    .ZERO_OUT   (sym_in[T_ZERO]),
    .ONE_OUT    (sym_in[T_ONE]),
    .FS_ACK     (ack[T_FS]),
    .FD_ACK     (ack[T_FD]),
    .FE_ACK     (ack[T_FE]),
    .X0_ACK     (ack[T_X0]),
    .ZERO_ACK   (ack[T_ZERO]),
    .ONE_ACK    (ack[T_ONE]),
    .word_data  (word_data),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .err_len    (err_len),
    .err_proto  (err_proto),
    .busy       (busy)
  );

  task automatic check_ok(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_eq(input string name, input longint act, input longint exp);
    check_ok(act == exp, name, act, exp);
  endtask

  task automatic check_le(input string name, input longint act, input longint lim);
    check_ok(act <= lim, name, act, lim);
  endtask

  always @(posedge clk) begin
    #1;
    word_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  // Per-cycle stream checks: ordering/content of accepted words, stability under stall.
  bit                prev_stall = 0;
  logic [ADDR_W:0]   prev_word = '0;
  always @(negedge clk) begin
    logic [ADDR_W:0] e;
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (err_len) n_len_seen++;
      if (err_proto) n_proto_seen++;
      check_le("ack_onehot", $countones(ack), 1);
      if (prev_stall) begin
        check_eq("stall_valid", word_valid, 1);
        check_eq("stall_word", {word_last, word_data}, prev_word);
      end
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          check_ok(1'b0, "unexpected_word", {word_last, word_data}, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("word", {word_last, word_data}, e);
        end
        acc_count++;
        last_acc_data = word_data;
        last_acc_last = word_last;
      end
      prev_stall = word_valid && !word_ready;
      prev_word  = {word_last, word_data};
    end
  end

  task automatic model_sym(input int s);
    bit fe;
    fe = (s == T_FE);
    case (s)
      T_FS: begin
        if (m_in) exp_proto++;
        m_in = 1; m_cnt = 0; m_ovf = 0; m_bits = '0;
      end
      T_ZERO, T_ONE: begin
        if (!m_in) exp_proto++;
        else if (m_cnt < ADDR_W) begin
          m_bits = (m_bits << 1) | ADDR_W'(s == T_ONE);
          m_cnt++;
        end else begin
          if (!m_ovf) exp_len++;
          m_ovf = 1;
        end
      end
      T_FD, T_FE: begin
        if (!m_in) exp_proto++;
        else begin
          if (m_cnt == ADDR_W && !m_ovf) exp_q.push_back({fe, m_bits});
          else if (!m_ovf) exp_len++;
          m_cnt = 0; m_ovf = 0;
          if (fe) m_in = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input int s);
    int  cyc;
    bit  is_del;
    is_del = (s == T_FD) || (s == T_FE);
    model_sym(s);
    sym_in[s] = 1'b1;
    cyc = 0;
    while (!ack[s] && cyc < 200) begin tick(); cyc++; end
    check_eq("ack_rise", ack[s], 1);
    if (!is_del || (!ready_rand && ready_force))
      check_le("ack_rise_latency", cyc, SYNC_STAGES + 2);
    sym_in[s] = 1'b0;
    cyc = 0;
    while (ack[s] && cyc < 200) begin tick(); cyc++; end
    check_eq("ack_fall", ack[s], 0);
    check_le("ack_fall_latency", cyc, SYNC_STAGES + 1);
    check_eq("err_len_count", n_len_seen, exp_len);
    check_eq("err_proto_count", n_proto_seen, exp_proto);
    check_eq("busy_after_handshake", busy, m_in);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_sym(v[i] ? T_ONE : T_ZERO);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, l0, p0, cyc, nw, nb;
    repeat (3) tick();
    check_eq("rst_ack", ack, 0);
    check_eq("rst_word_valid", word_valid, 0);
    check_eq("rst_word_last", word_last, 0);
    check_eq("rst_word_data", word_data, 0);
    check_eq("rst_err_len", err_len, 0);
    check_eq("rst_err_proto", err_proto, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // single word, Fe-terminated
    a0 = acc_count; l0 = n_len_seen; p0 = n_proto_seen;
    send_sym(T_FS); send_bits(16'hB2, 8); send_sym(T_FE);
    repeat (3) tick();
    check_eq("t1_words", acc_count - a0, 1);
    check_eq("t1_data", last_acc_data, 8'hB2);
    check_eq("t1_last", last_acc_last, 1);
    check_eq("t1_errs", (n_len_seen - l0) + (n_proto_seen - p0), 0);
    check_eq("t1_busy", busy, 0);

    // multi-word frame
    a0 = acc_count;
    send_sym(T_FS); send_bits(16'h5A, 8); send_sym(T_FD);
    repeat (3) tick();
    check_eq("t2_data0", last_acc_data, 8'h5A);
    check_eq("t2_last0", last_acc_last, 0);
    send_bits(16'h3C, 8); send_sym(T_FE);
    repeat (3) tick();
    check_eq("t2_data1", last_acc_data, 8'h3C);
    check_eq("t2_last1", last_acc_last, 1);
    check_eq("t2_words", acc_count - a0, 2);

    // backpressure: second delimiter must wait in S_HOLD
    ready_force = 0;
    repeat (2) tick();
    send_sym(T_FS); send_bits(16'h11, 8); send_sym(T_FD);
    check_eq("t3_valid_held", word_valid, 1);
    check_eq("t3_data_held", word_data, 8'h11);
    send_bits(16'h22, 8);
    model_sym(T_FD);
    sym_in[T_FD] = 1'b1;
    repeat (10) tick();
    check_eq("t3_fd_ack_low", ack[T_FD], 0);
    check_eq("t3_hold_state", int'(dut.state), int'(S_HOLD));
    a0 = acc_count;
    ready_force = 1;
    cyc = 0;
    while (!ack[T_FD] && cyc < 20) begin tick(); cyc++; end
    check_eq("t3_fd_ack_rise", ack[T_FD], 1);
    check_eq("t3_accept_same_cycle", acc_count - a0, 1);
    check_eq("t3_first_word", last_acc_data, 8'h11);
    check_eq("t3_second_loaded", word_data, 8'h22);
    check_eq("t3_second_valid", word_valid, 1);
    sym_in[T_FD] = 1'b0;
    cyc = 0;
    while (ack[T_FD] && cyc < 20) begin tick(); cyc++; end
    check_eq("t3_fd_ack_fall", ack[T_FD], 0);
    send_bits(16'h33, 8); send_sym(T_FE);
    repeat (3) tick();
    check_eq("t3_close", last_acc_data, 8'h33);

    // length errors
    a0 = acc_count; l0 = n_len_seen;
    send_sym(T_FS); send_bits(16'h15, 5); send_sym(T_FE);
    repeat (3) tick();
    check_eq("t4_short_err", n_len_seen - l0, 1);
    check_eq("t4_short_noword", acc_count - a0, 0);
    l0 = n_len_seen;
    send_sym(T_FS); send_bits(16'h1A5, 9); send_sym(T_FD);
    repeat (3) tick();
    check_eq("t4_long_err", n_len_seen - l0, 1);
    check_eq("t4_long_noword", acc_count - a0, 0);
    check_eq("t4_frame_open", busy, 1);
    send_sym(T_FE);

    // protocol errors
    p0 = n_proto_seen;
    send_sym(T_ONE);
    check_eq("t5_stray_bit", n_proto_seen - p0, 1);
    p0 = n_proto_seen; a0 = acc_count;
    send_sym(T_FS); send_sym(T_FS);
    check_eq("t5_double_fs", n_proto_seen - p0, 1);
    send_bits(16'hA7, 8); send_sym(T_FE);
    repeat (3) tick();
    check_eq("t5_clean_word", last_acc_data, 8'hA7);
    check_eq("t5_words", acc_count - a0, 1);

    // two symbols high at once never qualify
    sym_in[T_FS] = 1'b1; sym_in[T_FD] = 1'b1;
    repeat (8) tick();
    check_eq("t6_no_ack", ack, 0);
    check_eq("t6_idle", busy, 0);
    sym_in = '0;
    repeat (5) tick();
    check_eq("t6_no_ack_after", ack, 0);

    // reset during FE handshake
    ready_force = 0;
    repeat (2) tick();
    send_sym(T_FS); send_bits(16'h99, 8);
    model_sym(T_FE);
    sym_in[T_FE] = 1'b1;
    cyc = 0;
    while (!ack[T_FE] && cyc < 20) begin tick(); cyc++; end
    check_eq("t7_fe_ack_up", ack[T_FE], 1);
    #2 reset = 1'b1;
    #1;
    check_eq("t7_ack_drop", ack, 0);
    check_eq("t7_valid_drop", word_valid, 0);
    check_eq("t7_busy_drop", busy, 0);
    sym_in = '0;
    exp_q.delete();
    m_in = 0; m_ovf = 0; m_cnt = 0; m_bits = '0;
    repeat (2) tick();
    reset = 1'b0;
    ready_force = 1;
    repeat (2) tick();
    a0 = acc_count;
    send_sym(T_FS); send_bits(16'h4D, 8); send_sym(T_FE);
    repeat (3) tick();
    check_eq("t7_after_reset", last_acc_data, 8'h4D);
    check_eq("t7_words", acc_count - a0, 1);

    // randomized frames with random consumer stalls
    ready_rand = 1;
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 9))
        0: send_sym(T_ONE);
        1: send_sym(T_FD);
        2: send_sym(T_X0);
        default: ;
      endcase
      send_sym(T_FS);
      if ($urandom_range(0, 7) == 0) send_sym(T_FS);
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        nb = ($urandom_range(0, 4) == 0) ? $urandom_range(ADDR_W - 2, ADDR_W + 2) : ADDR_W;
        send_bits(16'($urandom), nb);
        if ($urandom_range(0, 5) == 0) send_sym(T_X0);
        send_sym((w == nw - 1) ? T_FE : T_FD);
      end
    end

    ready_rand = 0;
    ready_force = 1;
    repeat (6) tick();
    check_eq("drain_queue", exp_q.size(), 0);
    check_eq("drain_valid", word_valid, 0);
    check_eq("drain_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
